// File: rtl/rr_arb_pkg.sv
// Shared constants, state encoding and grant bundle for the 8-way arbiter.
package rr_arb_pkg;
  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  // Everything that is driven on the grant outputs, bundled together.
  typedef struct packed {
    logic              vld;
    logic [ID_W-1:0]   id;
    logic [N_REQ-1:0]  oh;
  } grant_t;

  // Binary index -> one-hot grant vector.
  function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/prio_pick8.sv
// Combinational picker: fixed priority (highest index wins) or
// round robin (first set bit searching upward from ptr, wrapping).
module prio_pick8
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] cand,
  input  logic [ID_W-1:0]  ptr,
  input  logic             mode,
  output logic [ID_W-1:0]  pick_id,
  output logic             pick_vld
);

  // Later loop iterations override earlier ones, so iteration order sets priority.
  always_comb begin
    logic [ID_W-1:0] idx;
    idx      = '0;
    pick_id  = '0;
    pick_vld = |cand;
    if (!mode) begin
      for (int i = 0; i < N_REQ; i++)
        if (cand[i]) pick_id = ID_W'(i);
    end else begin
      // Walk offsets from farthest to nearest so the nearest-to-ptr hit sticks.
      for (int i = N_REQ - 1; i >= 0; i--) begin
        idx = ptr + ID_W'(i);
        if (cand[idx]) pick_id = idx;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-requester arbiter with fixed-priority / round-robin modes, a hold
// limit that pre-empts a long-running owner when others wait, and fully
// registered grant outputs.
module rr_arbiter_8
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             mode,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_vld
);

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

  state_t           state, nxt_state;
  logic [ID_W-1:0]  ptr, nxt_ptr;
  logic [7:0]       hold_cnt, nxt_hold;
  grant_t           nxt_g;

  logic             owner_req, others, preempt, arb;
  logic [N_REQ-1:0] cand;
  logic [ID_W-1:0]  pick_id;
  logic             pick_vld;

  // Arbitration happens when idle, when the owner lets go, or when the
  // owner has hit the hold limit while someone else is waiting.
  always_comb begin
    owner_req = req[gnt_id];
    others    = |(req & ~gnt);
    preempt   = (state == OWNED) && (hold_cnt == HOLD_LIM) && owner_req && others;
    arb       = (state == IDLE) || !owner_req || preempt;
    // Masking the current owner is harmless when it has dropped its req,
    // and is exactly what pre-emption needs.
    cand      = (state == IDLE) ? req : (req & ~gnt);
  end

  prio_pick8 u_pick (
    .cand     (cand),
    .ptr      (ptr),
    .mode     (mode),
    .pick_id  (pick_id),
    .pick_vld (pick_vld)
  );

  // State, pointer, hold counter and grant registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      gnt_id   <= '0;
      gnt_vld  <= 1'b0;
    end else begin
      state    <= nxt_state;
      ptr      <= nxt_ptr;
      hold_cnt <= nxt_hold;
      gnt      <= nxt_g.oh;
      gnt_id   <= nxt_g.id;
      gnt_vld  <= nxt_g.vld;
    end
  end

  // Next-state: any arbitration event lands in OWNED if someone is picked, else IDLE.
  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:    if (pick_vld) nxt_state = OWNED;
      OWNED:   if (arb && !pick_vld) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // Next grant outputs, pointer and hold count.
  always_comb begin
    nxt_g.vld = gnt_vld;
    nxt_g.id  = gnt_id;
    nxt_g.oh  = gnt;
    nxt_ptr   = ptr;
    nxt_hold  = hold_cnt;
    if (arb) begin
      nxt_hold = '0;
      if (pick_vld) begin
        nxt_g.vld = 1'b1;
        nxt_g.id  = pick_id;
        nxt_g.oh  = onehot(pick_id);
        nxt_ptr   = pick_id + ID_W'(1);
      end else begin
        nxt_g.vld = 1'b0;
        nxt_g.id  = '0;
        nxt_g.oh  = '0;
      end
    end else if (hold_cnt != HOLD_LIM) begin
      nxt_hold = hold_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
module tb_rr_arbiter_8;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       mode;
  logic [7:0] g16, g4;
  logic [2:0] id16, id4;
  logic       v16, v4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_arbiter_8 u16 (
    .clk(clk), .rst(rst), .req(req), .mode(mode),
    .gnt(g16), .gnt_id(id16), .gnt_vld(v16)
  );

  rr_arbiter_8 #(.MAX_HOLD(4)) u4 (
    .clk(clk), .rst(rst), .req(req), .mode(mode),
    .gnt(g4), .gnt_id(id4), .gnt_vld(v4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 8'h00;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req  = 8'hFF;
    mode = 1'b0;
    tick();
    checks++;
    if ({g16, id16, v16} !== {8'h00, 3'd0, 1'b0} || {g4, id4, v4} !== {8'h00, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got gnt=%h id=%0d vld=%b / gnt=%h id=%0d vld=%b, want 00/0/0",
               g16, id16, v16, g4, id4, v4);
    end
    rst = 1'b0;
    req = 8'h00;
    tick();
    checks++;
    if ({g16, id16, v16} !== {8'h00, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL idle_noreq: got gnt=%h id=%0d vld=%b, want 00/0/0", g16, id16, v16);
    end
  endtask

  task automatic test_fixed();
    do_reset();
    mode = 1'b0;
    req  = 8'b01010101;
    tick();
    checks++;
    if ({g16, id16, v16} !== {8'b01000000, 3'd6, 1'b1}) begin
      failures++;
      $display("FAIL fixed_first: got gnt=%b id=%0d vld=%b, want 01000000/6/1", g16, id16, v16);
    end
    // Higher request and a mode change must not disturb the owner.
    req  = 8'b11010101;
    mode = 1'b1;
    tick();
    checks++;
    if ({g16, id16, v16} !== {8'b01000000, 3'd6, 1'b1}) begin
      failures++;
      $display("FAIL fixed_hold: got gnt=%b id=%0d vld=%b, want 01000000/6/1", g16, id16, v16);
    end
    // Owner drops: ptr=7 after granting 6, round robin now picks 7.
    req = 8'b10010101;
    tick();
    checks++;
    if ({g16, id16, v16} !== {8'b10000000, 3'd7, 1'b1}) begin
      failures++;
      $display("FAIL mode_switch_rr: got gnt=%b id=%0d vld=%b, want 10000000/7/1", g16, id16, v16);
    end
    // Drop 7 in fixed mode: highest remaining is 4.
    mode = 1'b0;
    req  = 8'b00010101;
    tick();
    checks++;
    if ({g16, id16, v16} !== {8'b00010000, 3'd4, 1'b1}) begin
      failures++;
      $display("FAIL fixed_rearb: got gnt=%b id=%0d vld=%b, want 00010000/4/1", g16, id16, v16);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] e;
    int nk;
    do_reset();
    mode = 1'b1;
    req  = 8'hFF;
    tick();
    checks++;
    if ({g16, id16, v16} !== {8'h01, 3'd0, 1'b1}) begin
      failures++;
      $display("FAIL rr_first: got gnt=%b id=%0d vld=%b, want 00000001/0/1", g16, id16, v16);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      e = 8'h01 << k;
      checks++;
      if ({g16, id16, v16} !== {e, 3'(k), 1'b1}) begin
        failures++;
        $display("FAIL rr_hold_%0d: got gnt=%b id=%0d vld=%b, want %b/%0d/1", k, g16, id16, v16, e, k);
      end
      req = 8'hFF & ~e;
      tick();
      req = 8'hFF;
      nk  = (k + 1) % 8;
      e   = 8'h01 << nk;
      checks++;
      if ({g16, id16, v16} !== {e, 3'(nk), 1'b1}) begin
        failures++;
        $display("FAIL rr_next_%0d: got gnt=%b id=%0d vld=%b, want %b/%0d/1", k, g16, id16, v16, e, nk);
      end
    end
  endtask

  task automatic test_preempt();
    do_reset();
    mode = 1'b0;
    req  = 8'h08;
    tick();
    checks++;
    if ({g4, id4, v4} !== {8'h08, 3'd3, 1'b1}) begin
      failures++;
      $display("FAIL preempt_grant3: got gnt=%b id=%0d vld=%b, want 00001000/3/1", g4, id4, v4);
    end
    req = 8'h28;
    for (int c = 2; c <= 4; c++) begin
      tick();
      checks++;
      if ({g4, id4, v4} !== {8'h08, 3'd3, 1'b1}) begin
        failures++;
        $display("FAIL preempt_hold_c%0d: got gnt=%b id=%0d vld=%b, want 00001000/3/1", c, g4, id4, v4);
      end
    end
    tick();
    checks++;
    if ({g4, id4, v4} !== {8'b00100000, 3'd5, 1'b1}) begin
      failures++;
      $display("FAIL preempt_move: got gnt=%b id=%0d vld=%b, want 00100000/5/1", g4, id4, v4);
    end
  endtask

  task automatic test_lone_owner();
    int bad;
    bad = 0;
    do_reset();
    mode = 1'b0;
    req  = 8'h04;
    for (int c = 0; c < 20; c++) begin
      tick();
      if ({g4, id4, v4} !== {8'h04, 3'd2, 1'b1}) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL lone_owner: %0d of 20 cycles off, last gnt=%b id=%0d vld=%b, want 00000100/2/1",
               bad, g4, id4, v4);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mode = 1'b0;
    req  = 8'h20;
    tick();
    checks++;
    if ({g16, id16, v16} !== {8'h20, 3'd5, 1'b1}) begin
      failures++;
      $display("FAIL midrst_setup: got gnt=%b id=%0d vld=%b, want 00100000/5/1", g16, id16, v16);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({g16, id16, v16} !== {8'h00, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL midrst_async: got gnt=%b id=%0d vld=%b, want 00000000/0/0", g16, id16, v16);
    end
    req  = 8'h21;
    mode = 1'b1;
    #1 rst = 1'b0;
    tick();
    checks++;
    if ({g16, id16, v16} !== {8'h01, 3'd0, 1'b1}) begin
      failures++;
      $display("FAIL midrst_rr: got gnt=%b id=%0d vld=%b, want 00000001/0/1", g16, id16, v16);
    end
  endtask

  task automatic test_release_idle();
    do_reset();
    mode = 1'b0;
    req  = 8'h10;
    tick();
    checks++;
    if ({g16, id16, v16} !== {8'h10, 3'd4, 1'b1}) begin
      failures++;
      $display("FAIL release_setup: got gnt=%b id=%0d vld=%b, want 00010000/4/1", g16, id16, v16);
    end
    req = 8'h00;
    tick();
    checks++;
    if ({g16, id16, v16} !== {8'h00, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL release_idle: got gnt=%b id=%0d vld=%b, want 00000000/0/0", g16, id16, v16);
    end
    // Back-to-back from idle: new request is granted the next edge.
    req = 8'h02;
    tick();
    checks++;
    if ({g16, id16, v16} !== {8'h02, 3'd1, 1'b1}) begin
      failures++;
      $display("FAIL idle_regrant: got gnt=%b id=%0d vld=%b, want 00000010/1/1", g16, id16, v16);
    end
  endtask

  initial begin
    rst  = 1'b1;
    req  = 8'h00;
    mode = 1'b0;
    test_reset();
    test_fixed();
    test_round_robin();
    test_preempt();
    test_lone_owner();
    test_reset_mid();
    test_release_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
